// File: rtl/lzc_tx.sv
// lzc_tx: serialises a width*word operand MSB word first to an lzc consumer and returns its count.
// Optional build macro LZC_TX_REF_EN adds a reference leading-zero check and the ref_mismatch output.
module lzc_tx #(
   parameter int unsigned width   = 8,
   parameter int unsigned word    = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [width*word-1:0]         operand,
   input  logic                          mode_in,
   input  logic                          hold,
   output logic                          busy,
   output logic [width-1:0]              data,
   output logic                          Ivalid,
   output logic                          mode,
   input  logic                          Ovalid,
   input  logic [$clog2(width*word):0]   zeros,
   output logic [$clog2(width*word):0]   result,
   output logic                          done,
   output logic                          err,
`ifdef LZC_TX_REF_EN
   output logic                          ref_mismatch,
`endif
   output logic [$clog2(word):0]         sent
);
   localparam int unsigned DW = width * word;
   localparam int unsigned ZW = $clog2(DW) + 1;
   localparam int unsigned SW = $clog2(word) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t          state;
   logic [DW-1:0]   shreg;
   logic [TW-1:0]   tcnt;
   logic            last_c;

   // The word on data this cycle ends the burst: count exhausted, or first non-zero word in turbo
   assign last_c = (sent == SW'(word - 1)) || (mode && (data != '0));

`ifdef LZC_TX_REF_EN
   logic [DW-1:0] opnd;

   function automatic logic [ZW-1:0] lzc(input logic [DW-1:0] v);
      logic [ZW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = DW - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n     = n + ZW'(1);
         end
      end
      return n;
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         data   <= '0;
         Ivalid <= 1'b0;
         mode   <= 1'b0;
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
         sent   <= '0;
         shreg  <= '0;
         tcnt   <= '0;
`ifdef LZC_TX_REF_EN
         opnd         <= '0;
         ref_mismatch <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (hold) begin
                     shreg  <= operand;
                     Ivalid <= 1'b0;
                  end else begin
                     data   <= operand[DW-1 -: width];
                     shreg  <= operand << width;
                     Ivalid <= 1'b1;
                  end
                  mode  <= mode_in;
                  sent  <= '0;
                  err   <= 1'b0;
                  tcnt  <= '0;
                  busy  <= 1'b1;
                  state <= SEND;
`ifdef LZC_TX_REF_EN
                  opnd         <= operand;
                  ref_mismatch <= 1'b0;
`endif
               end
            end
            SEND: begin
               // Consumer completion wins over sending the remaining words
               if (Ovalid) begin
                  result <= zeros;
                  Ivalid <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
                  if (Ivalid) sent <= sent + SW'(1);
`ifdef LZC_TX_REF_EN
                  ref_mismatch <= (zeros != lzc(opnd));
`endif
               end else if (Ivalid) begin
                  sent <= sent + SW'(1);
                  if (last_c) begin
                     Ivalid <= 1'b0;
                     tcnt   <= '0;
                     state  <= WAIT;
                  end else if (hold) begin
                     Ivalid <= 1'b0;
                  end else begin
                     data  <= shreg[DW-1 -: width];
                     shreg <= shreg << width;
                  end
               end else if (!hold) begin
                  data   <= shreg[DW-1 -: width];
                  shreg  <= shreg << width;
                  Ivalid <= 1'b1;
               end
            end
            WAIT: begin
               if (Ovalid) begin
                  result <= zeros;
                  done   <= 1'b1;
                  state  <= DONE;
`ifdef LZC_TX_REF_EN
                  ref_mismatch <= (zeros != lzc(opnd));
`endif
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  result <= '0;
                  err    <= 1'b1;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lzc_tx.sv
// tb_lzc_tx: directed-vector bench for lzc_tx with hand-computed expectations.
// Build with LZC_TX_REF_EN defined to also cover ref_mismatch.
module tb_lzc_tx;
   logic        clk = 1'b0;
   logic        rst, start, mode_in, hold, Ovalid;
   logic [31:0] operand;
   logic [5:0]  zeros;
   logic        busy, Ivalid, mode, done, err;
   logic [7:0]  data;
   logic [5:0]  result;
   logic [2:0]  sent;
`ifdef LZC_TX_REF_EN
   logic        ref_mismatch;
`endif

   int checks   = 0;
   int failures = 0;

   int          nw, span, k;
   logic [31:0] st;

   always #5 clk = ~clk;

   lzc_tx #(.width(8), .word(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .operand(operand), .mode_in(mode_in),
      .hold(hold), .busy(busy), .data(data), .Ivalid(Ivalid), .mode(mode),
      .Ovalid(Ovalid), .zeros(zeros), .result(result), .done(done), .err(err),
`ifdef LZC_TX_REF_EN
      .ref_mismatch(ref_mismatch),
`endif
      .sent(sent)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand and collect the word stream until the burst ends
   task automatic send_tx(input logic [31:0] op, input logic m, input int hold_after,
                          input int hold_cycles, input bit spam,
                          output int nwords, output logic [31:0] stream, output int sp);
      int   hcnt, first, lastc;
      logic ph;
      bit   fin;
      nwords = 0; stream = '0; hcnt = 0; first = -1; lastc = -1; ph = 1'b0; fin = 1'b0;
      operand = op; mode_in = m; start = 1'b1; hold = 1'b0;
      tick();
      if (spam) begin
         operand = ~op;
         mode_in = ~m;
      end else begin
         start = 1'b0;
      end
      check("busy_acc", 64'(busy), 64'(1));
      for (int c = 0; c < 30 && !fin; c++) begin
         if (c == 0) check("ivalid_t1", 64'(Ivalid), 64'(1));
         if (Ivalid) begin
            stream = {stream[23:0], data};
            nwords++;
            if (first < 0) first = c;
            lastc = c;
         end
         if (nwords > 0 && !Ivalid && !ph) begin
            fin = 1'b1;
         end else begin
            ph = (nwords == hold_after) && (hcnt < hold_cycles);
            if (ph) hcnt++;
            hold = ph;
            tick();
         end
      end
      start = 1'b0;
      hold  = 1'b0;
      if (!fin) check("send_bound", 64'(0), 64'(1));
      sp = lastc - first + 1;
   endtask

   task automatic respond(input logic [5:0] z, input logic exp_ref);
      Ovalid = 1'b1;
      zeros  = z;
      tick();
      Ovalid = 1'b0;
      check("done_pulse", 64'(done), 64'(1));
      check("result", 64'(result), 64'(z));
      check("err_clear", 64'(err), 64'(0));
      check("busy_done", 64'(busy), 64'(1));
`ifdef LZC_TX_REF_EN
      check("ref_mismatch", 64'(ref_mismatch), 64'(exp_ref));
`else
      if (exp_ref) check("ref_unused", 64'(0), 64'(0));
`endif
      tick();
      check("done_low", 64'(done), 64'(0));
      check("busy_idle", 64'(busy), 64'(0));
      check("result_hold", 64'(result), 64'(z));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode_in = 1'b0; hold = 1'b0; Ovalid = 1'b0;
      operand = '0; zeros = '0;
      tick(); tick();
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ivalid", 64'(Ivalid), 64'(0));
      check("rst_data", 64'(data), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_sent", 64'(sent), 64'(0));
      rst = 1'b0;
      tick();

      // Ovalid while idle is ignored
      Ovalid = 1'b1; zeros = 6'd5;
      tick();
      Ovalid = 1'b0;
      check("idle_ovalid_done", 64'(done), 64'(0));
      check("idle_ovalid_result", 64'(result), 64'(0));

      // Normal mode
      send_tx(32'h000010FF, 1'b0, -1, 0, 1'b0, nw, st, span);
      check("n_words", 64'(nw), 64'(4));
      check("n_stream", 64'(st), 64'h000010FF);
      check("n_span", 64'(span), 64'(4));
      check("n_sent", 64'(sent), 64'(4));
      check("n_mode", 64'(mode), 64'(0));
      check("n_data_hold", 64'(data), 64'hFF);
      respond(6'd19, 1'b0);
      check("n_sent_hold", 64'(sent), 64'(4));

      // Turbo mode stops after the first non-zero word
      send_tx(32'h000010FF, 1'b1, -1, 0, 1'b0, nw, st, span);
      check("t_words", 64'(nw), 64'(3));
      check("t_stream", 64'(st), 64'h00000010);
      check("t_sent", 64'(sent), 64'(3));
      check("t_mode", 64'(mode), 64'(1));
      respond(6'd19, 1'b0);

      // Turbo mode with an all-zero operand sends every word
      send_tx(32'h00000000, 1'b1, -1, 0, 1'b0, nw, st, span);
      check("z_words", 64'(nw), 64'(4));
      check("z_stream", 64'(st), 64'h0);
      check("z_sent", 64'(sent), 64'(4));
      respond(6'd32, 1'b0);

      // Hold after the second word, with start held high during busy
      send_tx(32'h12345678, 1'b0, 2, 2, 1'b1, nw, st, span);
      check("h_words", 64'(nw), 64'(4));
      check("h_stream", 64'(st), 64'h12345678);
      check("h_span", 64'(span), 64'(6));
      check("h_mode", 64'(mode), 64'(0));
      respond(6'd3, 1'b0);

      // Timeout: done and err TIMEOUT cycles after entering WAIT
      send_tx(32'h80000000, 1'b0, -1, 0, 1'b0, nw, st, span);
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      check("to_cycles", 64'(k), 64'(16));
      check("to_err", 64'(err), 64'(1));
      check("to_result", 64'(result), 64'(0));
      check("to_sent", 64'(sent), 64'(4));
      tick();
      check("to_idle", 64'(busy), 64'(0));
      check("to_err_hold", 64'(err), 64'(1));

      // Ovalid during SEND aborts remaining words
      operand = 32'hFFFFFFFF; mode_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      Ovalid = 1'b1; zeros = 6'd7;
      tick();
      Ovalid = 1'b0;
      check("ab_done", 64'(done), 64'(1));
      check("ab_result", 64'(result), 64'(7));
      check("ab_err", 64'(err), 64'(0));
      check("ab_ivalid", 64'(Ivalid), 64'(0));
`ifdef LZC_TX_REF_EN
      check("ab_ref", 64'(ref_mismatch), 64'(1));
`endif
      tick();
      check("ab_idle", 64'(busy), 64'(0));

`ifdef LZC_TX_REF_EN
      send_tx(32'h000010FF, 1'b0, -1, 0, 1'b0, nw, st, span);
      respond(6'd18, 1'b1);
`endif

      // Reset in the middle of SEND
      send_tx(32'h000010FF, 1'b0, -1, 0, 1'b0, nw, st, span);
      respond(6'd19, 1'b0);
      operand = 32'hAABBCCDD; mode_in = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("r_first", 64'(data), 64'hAA);
      tick();
      rst = 1'b1;
      tick();
      check("r_busy", 64'(busy), 64'(0));
      check("r_ivalid", 64'(Ivalid), 64'(0));
      check("r_data", 64'(data), 64'(0));
      check("r_mode", 64'(mode), 64'(0));
      check("r_sent", 64'(sent), 64'(0));
      check("r_result", 64'(result), 64'(0));
      check("r_done", 64'(done), 64'(0));
      check("r_err", 64'(err), 64'(0));
      rst = 1'b0;
      tick();
      check("r_stay_idle", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
